hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, operand forwarding,
// data-memory wait handling with timeout, and a stall-cycle performance counter.
module hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MemErr,
  output logic [CNT_W-1:0]  StallCycles
);

  localparam int unsigned WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic timeout;
  logic mem_stall;
  logic load_use;
  logic m_hit_a, w_hit_a, m_hit_b, w_hit_b;

  // The timeout cycle itself already releases the pipeline, before MemErr is registered.
  assign timeout   = (state_q == MEM_WAIT) && (wcnt_q == WAIT_LAST) && !MemReadyM;
  assign mem_stall = MemReqM && !MemReadyM && !mem_err_q && !timeout;
  assign load_use  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  assign m_hit_a = RegWriteM && (RdM != '0) && (RdM == Rs1E);
  assign w_hit_a = RegWriteW && (RdW != '0) && (RdW == Rs1E);
  assign m_hit_b = RegWriteM && (RdM != '0) && (RdM == Rs2E);
  assign w_hit_b = RegWriteW && (RdW != '0) && (RdW == Rs2E);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = '0;
    mem_err_d = mem_err_q;
    case (state_q)
      RUN: begin
        if (mem_stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (MemReadyM || timeout) begin
          state_d = RUN;
        end else begin
          wcnt_d = WCNT_W'(wcnt_q + 1'b1);
        end
        if (timeout) mem_err_d = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Hazard outputs: memory stall dominates, then branch flush, then load-use.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      ForwardAE = m_hit_a ? 2'b10 : (w_hit_a ? 2'b01 : 2'b00);
      ForwardBE = m_hit_b ? 2'b10 : (w_hit_b ? 2'b01 : 2'b00);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF && (stall_cnt_q != CNT_MAX)) stall_cnt_d = CNT_W'(stall_cnt_q + 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MemErr      = mem_err_q;
  assign StallCycles = stall_cnt_q;

endmodule
